// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte-granular instruction prefetch queue; optional PREFETCH_QUEUE_PERF_EN perf counters
module prefetch_queue #(
    parameter int          DEPTH_BYTES = 16,
    parameter logic [31:0] RESET_EIP   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ope,
    output logic        ope_valid,
    output logic [31:0] eip,
    input  logic        consume,
    input  logic [3:0]  consume_len,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t        r_state, w_state_nxt;
    logic          w_load_req;
    logic [7:0]    r_mem [DEPTH_BYTES];
    logic [7:0]    w_mem_nxt [DEPTH_BYTES];
    logic [CW-1:0] r_count, w_count_nxt, w_space, w_adv;
    logic [AW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
    logic [31:0]   r_eip, w_eip_nxt, r_fetch_ptr, r_mem_addr, r_ope, w_ope_nxt;
    logic [1:0]    r_skip;
    logic          r_ope_valid, r_err;
    logic          w_len_ok, w_cons, w_bad, w_fill;
    logic [2:0]    w_push;

    // Consume legality, fill detection and next queue bookkeeping; flush overrides everything
    always_comb begin
        w_space     = CW'(DEPTH_BYTES) - r_count;
        w_len_ok    = (consume_len != 4'd0) && (consume_len <= 4'd8)
                      && (32'(consume_len) <= 32'(r_count));
        w_cons      = consume && !flush && w_len_ok;
        w_bad       = consume && !flush && !w_len_ok;
        w_fill      = (r_state == S_REQ) && mem_ack && !flush;
        w_adv       = w_cons ? CW'(consume_len) : '0;
        w_push      = w_fill ? (3'd4 - {1'b0, r_skip}) : 3'd0;
        w_count_nxt = flush ? '0 : (r_count - w_adv + CW'(w_push));
        w_head_nxt  = flush ? '0 : (r_head + AW'(w_adv));
        w_tail_nxt  = flush ? '0 : (r_tail + AW'(w_push));
        w_eip_nxt   = flush ? flush_addr : (r_eip + (w_cons ? 32'(consume_len) : 32'd0));
    end

    // Next byte-array contents: fetched word lands big-endian, leading skip bytes dropped
    always_comb begin
        w_mem_nxt = r_mem;
        for (int k = 0; k < 4; k++) begin
            if (w_fill && (k >= int'(r_skip))) begin
                w_mem_nxt[r_tail + AW'(k - int'(r_skip))] = mem_rdata[31-8*k -: 8];
            end
        end
    end

    // Next decode window taken from the post-edge queue, empty lanes read as zero
    always_comb begin
        w_ope_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            if (CW'(i) < w_count_nxt) begin
                w_ope_nxt[31-8*i -: 8] = w_mem_nxt[w_head_nxt + AW'(i)];
            end
        end
    end

    // Fetch FSM next state: request when a whole word fits, drain a redirected request
    always_comb begin
        w_state_nxt = r_state;
        w_load_req  = 1'b0;
        mem_req     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (!flush && (w_space >= CW'(4))) begin
                    w_state_nxt = S_REQ;
                    w_load_req  = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_ack)    w_state_nxt = S_IDLE;
                else if (flush) w_state_nxt = S_DROP;
            end
            S_DROP: begin
                if (mem_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Queue storage needs no reset: lanes beyond count are never presented
    always_ff @(posedge clk) begin
        r_mem <= w_mem_nxt;
    end

    // Queue pointers, fetch pointer, request address, decode window and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_eip       <= RESET_EIP;
            r_fetch_ptr <= RESET_EIP & ~32'h3;
            r_skip      <= RESET_EIP[1:0];
            r_mem_addr  <= '0;
            r_ope       <= '0;
            r_ope_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_eip       <= w_eip_nxt;
            r_ope       <= w_ope_nxt;
            r_ope_valid <= (w_count_nxt >= CW'(4));
            if (w_load_req) r_mem_addr <= r_fetch_ptr;
            if (flush) begin
                r_fetch_ptr <= flush_addr & ~32'h3;
                r_skip      <= flush_addr[1:0];
            end else if (w_fill) begin
                r_fetch_ptr <= r_fetch_ptr + 32'd4;
                r_skip      <= 2'd0;
            end
            if (w_bad) r_err <= 1'b1;
        end
    end

`ifdef PREFETCH_QUEUE_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;

    // Saturating stall and flush counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!r_ope_valid && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (flush && (flush_cnt != 16'hFFFF))        flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

    assign mem_addr  = r_mem_addr;
    assign ope       = r_ope;
    assign ope_valid = r_ope_valid;
    assign eip       = r_eip;
    assign err       = r_err;
endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - directed self-checking bench for prefetch_queue
module tb_prefetch_queue;
    logic        clk, reset, mem_req, mem_ack, ope_valid, consume, flush, err;
    logic [31:0] mem_addr, mem_rdata, ope, eip, flush_addr;
    logic [3:0]  consume_len;
    logic        mem_en;
    int          n_cmp, n_fail;

    prefetch_queue dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ope(ope), .ope_valid(ope_valid),
        .eip(eip), .consume(consume), .consume_len(consume_len), .flush(flush),
        .flush_addr(flush_addr), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0, 32'h4: mem_word = 32'hB802_0000;
            32'h8:        mem_word = 32'h89E5_5D55;
            32'hC:        mem_word = 32'hC300_0000;
            32'h100:      mem_word = 32'h1122_3344;
            32'h104:      mem_word = 32'h5566_7788;
            default:      mem_word = {a[7:0], a[7:0] + 8'd1, a[7:0] + 8'd2, a[7:0] + 8'd3};
        endcase
    endfunction

    // one clock; afterwards the memory model answers a pending request with a 1-cycle ack
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_ack) mem_ack = 1'b0;
        else if (mem_req && mem_en) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_en = 1'b0; consume = 1'b0; flush = 1'b0;
        tick(); tick();
        n_cmp++; if (ope !== 32'h0)   begin n_fail++; $display("FAIL reset_ope: got %h want 0", ope); end
        n_cmp++; if (ope_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ope_valid: got %b want 0", ope_valid); end
        n_cmp++; if (eip !== 32'h0)   begin n_fail++; $display("FAIL reset_eip: got %h want 0", eip); end
        n_cmp++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_fill();
        reset = 1'b0; mem_en = 1'b1;
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL fill_req0: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
        n_cmp++; if (ope_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid: got %b want 0", ope_valid); end
        tick();
        n_cmp++; if (ope_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b want 1", ope_valid); end
        n_cmp++; if (ope !== 32'hB802_0000) begin n_fail++; $display("FAIL fill_ope: got %h want b8020000", ope); end
        n_cmp++; if (eip !== 32'h0) begin n_fail++; $display("FAIL fill_eip: got %h want 0", eip); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL fill_req4: got req=%b addr=%h want 1/4", mem_req, mem_addr); end
        repeat (8) tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_no_req: got %b want 0", mem_req); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL fill_err: got %b want 0", err); end
    endtask

    task automatic test_consume();
        mem_en = 1'b0;
        consume = 1'b1; consume_len = 4'd4; tick(); consume = 1'b0;
        n_cmp++; if (eip !== 32'h4) begin n_fail++; $display("FAIL cons4_eip: got %h want 4", eip); end
        n_cmp++; if (ope !== 32'hB802_0000) begin n_fail++; $display("FAIL cons4_ope: got %h want b8020000", ope); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL space_req: got req=%b addr=%h want 1/10", mem_req, mem_addr); end
        consume = 1'b1; consume_len = 4'd4; tick();
        n_cmp++; if (ope !== 32'h89E5_5D55 || eip !== 32'h8) begin n_fail++; $display("FAIL cons8: got ope=%h eip=%h want 89e55d55/8", ope, eip); end
        consume_len = 4'd2; tick(); consume = 1'b0;
        n_cmp++; if (ope !== 32'h5D55_C300) begin n_fail++; $display("FAIL cons2_ope: got %h want 5d55c300", ope); end
        n_cmp++; if (eip !== 32'hA) begin n_fail++; $display("FAIL cons2_eip: got %h want a", eip); end
    endtask

    task automatic test_flush_drop();
        flush = 1'b1; flush_addr = 32'h0000_0103; tick(); flush = 1'b0;
        n_cmp++; if (eip !== 32'h103) begin n_fail++; $display("FAIL flush_eip: got %h want 103", eip); end
        n_cmp++; if (ope_valid !== 1'b0 || ope !== 32'h0) begin n_fail++; $display("FAIL flush_empty: got v=%b ope=%h want 0/0", ope_valid, ope); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL drop_hold: got req=%b addr=%h want 1/10", mem_req, mem_addr); end
        mem_en = 1'b1;
        tick(); tick();
        n_cmp++; if (ope !== 32'h0 || ope_valid !== 1'b0) begin n_fail++; $display("FAIL drop_discard: got ope=%h v=%b want 0/0", ope, ope_valid); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL redirect_addr: got req=%b addr=%h want 1/100", mem_req, mem_addr); end
        tick();
        n_cmp++; if (ope !== 32'h4400_0000 || ope_valid !== 1'b0) begin n_fail++; $display("FAIL skip3: got ope=%h v=%b want 44000000/0", ope, ope_valid); end
        tick(); tick();
        n_cmp++; if (ope !== 32'h4455_6677 || ope_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_ope: got ope=%h v=%b want 44556677/1", ope, ope_valid); end
        n_cmp++; if (eip !== 32'h103) begin n_fail++; $display("FAIL redirect_eip: got %h want 103", eip); end
    endtask

    task automatic test_err();
        bit hit;
        mem_en = 1'b0;
        flush = 1'b1; flush_addr = 32'h0000_0201; tick(); flush = 1'b0;
        mem_en = 1'b1; hit = 1'b0;
        for (int t = 0; t < 20 && !hit; t++) begin
            tick();
            if (ope === 32'h0102_0300) hit = 1'b1;
        end
        mem_en = 1'b0;
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL err_setup: timeout ope=%h want 01020300", ope); end
        consume = 1'b1; consume_len = 4'd5; tick(); consume = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_len_gt_count: got %b want 1", err); end
        n_cmp++; if (eip !== 32'h201 || ope !== 32'h0102_0300) begin n_fail++; $display("FAIL err_ignored: got eip=%h ope=%h want 201/01020300", eip, ope); end
        consume = 1'b1; consume_len = 4'd0; tick(); consume = 1'b0;
        tick(); tick();
        n_cmp++; if (err !== 1'b1 || eip !== 32'h201) begin n_fail++; $display("FAIL err_sticky: got err=%b eip=%h want 1/201", err, eip); end
    endtask

    task automatic test_flush_priority();
        int fc_before;
        fc_before = 0;
`ifdef PREFETCH_QUEUE_PERF_EN
        fc_before = int'(dut.flush_cnt);
`endif
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL prio_pending: got %b want 1", mem_req); end
        consume = 1'b1; consume_len = 4'd1; flush = 1'b1; flush_addr = 32'h0000_0302;
        mem_ack = 1'b1; mem_rdata = 32'hAABB_CCDD;
        tick();
        consume = 1'b0; flush = 1'b0;
        n_cmp++; if (eip !== 32'h302) begin n_fail++; $display("FAIL prio_eip: got %h want 302", eip); end
        n_cmp++; if (ope !== 32'h0 || ope_valid !== 1'b0) begin n_fail++; $display("FAIL prio_empty: got ope=%h v=%b want 0/0", ope, ope_valid); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b want 0", mem_req); end
`ifdef PREFETCH_QUEUE_PERF_EN
        n_cmp++; if (int'(dut.flush_cnt) !== fc_before + 1) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", dut.flush_cnt, fc_before + 1); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_eip;
        logic [7:0]  e;
        int          n;
        exp_eip = 32'h302; n = 0; mem_en = 1'b1;
        for (int t = 0; t < 300 && n < 12; t++) begin
            if (ope_valid === 1'b1) begin
                e = exp_eip[7:0];
                n_cmp++; if (ope !== {e, e + 8'd1, e + 8'd2, e + 8'd3}) begin n_fail++; $display("FAIL b2b_ope[%0d]: got %h want %h", n, ope, {e, e + 8'd1, e + 8'd2, e + 8'd3}); end
                n_cmp++; if (eip !== exp_eip) begin n_fail++; $display("FAIL b2b_eip[%0d]: got %h want %h", n, eip, exp_eip); end
                consume = 1'b1; consume_len = 4'(1 + n % 4);
                exp_eip = exp_eip + 32'(1 + n % 4);
                n++;
            end else begin
                consume = 1'b0;
            end
            tick();
        end
        consume = 1'b0;
        n_cmp++; if (n != 12) begin n_fail++; $display("FAIL b2b_timeout: got %0d consumes want 12", n); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL b2b_err_sticky: got %b want 1", err); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; mem_en = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        consume = 1'b0; consume_len = 4'd0; flush = 1'b0; flush_addr = 32'h0;
        test_reset();
        test_fill();
        test_consume();
        test_flush_drop();
        test_err();
        test_flush_priority();
        test_back_to_back();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
